// File: rtl/lru_state_array_pkg.sv
// Shared cache type definitions for the PLRU state array.
// Holds lru_t, PLRU_RESET, set-count constants and the array FSM states.
package cache_types;

    localparam int NUM_SETS  = 16;
    localparam int SET_IDX_W = $clog2(NUM_SETS);

    typedef logic [2:0] lru_t;

    localparam lru_t PLRU_RESET = 3'b000;

    typedef enum logic {
        LA_INIT,
        LA_READY
    } lru_arr_state_t;

endpackage

// File: rtl/lru_parity_gen.sv
// Even-parity generator for one PLRU entry.
// Ports: i_data (W bits in), o_par (XOR of i_data, 1 bit out).
module lru_parity_gen #(
    parameter int W = 3
) (
    input  logic [W-1:0] i_data,
    output logic         o_par
);

    assign o_par = ^i_data;

endmodule

// File: rtl/lru_state_array.sv
// Per-set 4-way tree-PLRU storage with reset sweep and write-first bypass.
// Ports: clk, rst (sync, active-high), ready, rd_en/rd_set -> rd_valid/rd_lru,
// wr_en/wr_set/wr_lru, parity_err. Optional: `LRU_PARITY_EN adds a parity bit
// per entry, flags/zeroes corrupt reads and scrubs the entry on the next edge.
module lru_state_array
    import cache_types::*;
#(
    parameter int NUM_SETS  = cache_types::NUM_SETS,
    parameter int SET_IDX_W = cache_types::SET_IDX_W,
    parameter int LRU_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic                 rd_en,
    input  logic [SET_IDX_W-1:0] rd_set,
    output logic                 rd_valid,
    output logic [LRU_W-1:0]     rd_lru,
    input  logic                 wr_en,
    input  logic [SET_IDX_W-1:0] wr_set,
    input  logic [LRU_W-1:0]     wr_lru,
    output logic                 parity_err
);

`ifdef LRU_PARITY_EN
    localparam int ENTRY_W = LRU_W + 1;
`else
    localparam int ENTRY_W = LRU_W;
`endif

    lru_arr_state_t       r_state;
    lru_arr_state_t       w_state_nxt;
    logic [SET_IDX_W-1:0] r_init_ptr;
    logic [ENTRY_W-1:0]   r_store [NUM_SETS];
    logic                 r_rd_valid;
    logic [LRU_W-1:0]     r_rd_lru;
    logic                 r_parity_err;

    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_bypass;
    logic [ENTRY_W-1:0]   w_rd_entry;
    logic [ENTRY_W-1:0]   w_wr_entry;
    logic                 w_rd_bad;
    logic                 w_scrub_hit;
    logic [LRU_W-1:0]     w_rd_data;

    assign ready      = (r_state == LA_READY);
    assign w_rd_acc   = ready && rd_en;
    assign w_wr_acc   = ready && wr_en;
    assign w_bypass   = w_rd_acc && w_wr_acc && (rd_set == wr_set);
    assign w_rd_entry = r_store[rd_set];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LA_INIT: begin
                if (r_init_ptr == SET_IDX_W'(NUM_SETS - 1))
                    w_state_nxt = LA_READY;
            end
            LA_READY: w_state_nxt = LA_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LA_INIT;
            r_init_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == LA_INIT)
                r_init_ptr <= r_init_ptr + SET_IDX_W'(1);
        end
    end

`ifdef LRU_PARITY_EN
    logic                 w_wr_par;
    logic                 w_rd_par;
    logic                 r_scrub_pend;
    logic [SET_IDX_W-1:0] r_scrub_set;

    lru_parity_gen #(.W(LRU_W)) u_wr_par (
        .i_data (wr_lru),
        .o_par  (w_wr_par)
    );

    lru_parity_gen #(.W(LRU_W)) u_rd_par (
        .i_data (w_rd_entry[LRU_W-1:0]),
        .o_par  (w_rd_par)
    );

    assign w_wr_entry  = {w_wr_par, wr_lru};
    // A read of the entry being scrubbed this edge already sees the clean value.
    assign w_scrub_hit = r_scrub_pend && (r_scrub_set == rd_set);
    assign w_rd_bad    = (w_rd_par != w_rd_entry[LRU_W]) && !w_scrub_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scrub_pend <= 1'b0;
            r_scrub_set  <= '0;
        end else begin
            r_scrub_pend <= w_rd_acc && !w_bypass && w_rd_bad;
            r_scrub_set  <= rd_set;
        end
    end
`else
    assign w_wr_entry  = wr_lru;
    assign w_scrub_hit = 1'b0;
    assign w_rd_bad    = 1'b0;
`endif

    always_comb begin
        w_rd_data = w_rd_entry[LRU_W-1:0];
        if (w_bypass)
            w_rd_data = wr_lru;
        else if (w_rd_bad || w_scrub_hit)
            w_rd_data = '0;
    end

    // Store is cleared by the sweep, not by rst directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == LA_INIT) begin
                r_store[r_init_ptr] <= ENTRY_W'(PLRU_RESET);
            end else begin
`ifdef LRU_PARITY_EN
                if (r_scrub_pend)
                    r_store[r_scrub_set] <= '0;
`endif
                // Later assignment: a write beats the scrub.
                if (w_wr_acc)
                    r_store[wr_set] <= w_wr_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid   <= 1'b0;
            r_rd_lru     <= LRU_W'(PLRU_RESET);
            r_parity_err <= 1'b0;
        end else begin
            r_rd_valid   <= w_rd_acc;
            r_parity_err <= w_rd_acc && !w_bypass && w_rd_bad;
            if (w_rd_acc)
                r_rd_lru <= w_rd_data;
        end
    end

    assign rd_valid   = r_rd_valid;
    assign rd_lru     = r_rd_lru;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_lru_state_array.sv
// Scoreboard bench for lru_state_array: directed reads push expectations,
// a negedge monitor pops and compares on every rd_valid.
module tb_lru_state_array;

    typedef struct {
        logic [2:0] lru;
        logic       perr;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready;
    logic       rd_en = 1'b0;
    logic [3:0] rd_set = '0;
    logic       rd_valid;
    logic [2:0] rd_lru;
    logic       wr_en = 1'b0;
    logic [3:0] wr_set = '0;
    logic [2:0] wr_lru = '0;
    logic       parity_err;

    exp_t q[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   stall_rdv = 0;
    int   n;

    lru_state_array dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .rd_en      (rd_en),
        .rd_set     (rd_set),
        .rd_valid   (rd_valid),
        .rd_lru     (rd_lru),
        .wr_en      (wr_en),
        .wr_set     (wr_set),
        .wr_lru     (wr_lru),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rd_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rd_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk(e.nm, int'({parity_err, rd_lru}),
                    int'({e.perr, e.lru}));
            end
        end else if (parity_err) begin
            chk("perr_without_valid", 1, 0);
        end
    end

    task automatic cyc(input logic re, input logic [3:0] rs,
                       input logic we, input logic [3:0] ws,
                       input logic [2:0] wl, input logic [2:0] el,
                       input logic ep, input string nm);
        exp_t e;
        @(negedge clk);
        rd_en  = re;
        rd_set = rs;
        wr_en  = we;
        wr_set = ws;
        wr_lru = wl;
        if (re) begin
            e.lru  = el;
            e.perr = ep;
            e.nm   = nm;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0, "");
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
            if (rd_valid) stall_rdv++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(ready), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_lru", int'(rd_lru), 0);
        chk("rst_perr", int'(parity_err), 0);
        rst = 1'b0;
        wait_ready(n);
        chk("ready_latency", n, 16);

        for (int s = 0; s < 16; s++)
            cyc(1'b1, 4'(s), 1'b0, 4'd0, 3'd0, 3'b000, 1'b0, "sweep_rd");

        cyc(1'b0, 4'd0, 1'b1, 4'd5, 3'b110, 3'd0, 1'b0, "");
        cyc(1'b1, 4'd5, 1'b0, 4'd0, 3'd0, 3'b110, 1'b0, "wr_rd_5");
        cyc(1'b1, 4'd4, 1'b0, 4'd0, 3'd0, 3'b000, 1'b0, "rd_4");

        cyc(1'b1, 4'd9, 1'b1, 4'd9, 3'b011, 3'b011, 1'b0, "bypass_9");
        cyc(1'b1, 4'd9, 1'b0, 4'd0, 3'd0, 3'b011, 1'b0, "after_byp_9");

        cyc(1'b1, 4'd4, 1'b1, 4'd6, 3'b001, 3'b000, 1'b0, "diff_rd_4");
        cyc(1'b1, 4'd6, 1'b0, 4'd0, 3'd0, 3'b001, 1'b0, "diff_rd_6");

        cyc(1'b0, 4'd0, 1'b1, 4'd1, 3'b101, 3'd0, 1'b0, "");
        cyc(1'b1, 4'd1, 1'b0, 4'd0, 3'd0, 3'b101, 1'b0, "hold_rd_1");
        cyc(1'b0, 4'd0, 1'b1, 4'd1, 3'b000, 3'd0, 1'b0, "");
        idle();
        idle();
        chk("hold_lru", int'(rd_lru), 5);
        chk("hold_valid", int'(rd_valid), 0);
        cyc(1'b1, 4'd1, 1'b0, 4'd0, 3'd0, 3'b000, 1'b0, "rd_1_new");
        idle();

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_en  = 1'b1;
        rd_set = 4'd2;
        wr_en  = 1'b1;
        wr_set = 4'd2;
        wr_lru = 3'b111;
        repeat (7) begin
            @(posedge clk);
            #1;
            if (rd_valid) stall_rdv++;
        end
        @(negedge clk);
        chk("mid_sweep_ready", int'(ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready(n);
        rd_en = 1'b0;
        wr_en = 1'b0;
        chk("mid_rst_latency", n, 16);
        chk("stall_no_valid", stall_rdv, 0);
        cyc(1'b1, 4'd2, 1'b0, 4'd0, 3'd0, 3'b000, 1'b0, "stall_rd_2");
        cyc(1'b1, 4'd5, 1'b0, 4'd0, 3'd0, 3'b000, 1'b0, "resweep_5");
        idle();

`ifdef LRU_PARITY_EN
        cyc(1'b0, 4'd0, 1'b1, 4'd3, 3'b010, 3'd0, 1'b0, "");
        idle();
        dut.r_store[3] = dut.r_store[3] ^ 4'b0001;
        cyc(1'b1, 4'd3, 1'b0, 4'd0, 3'd0, 3'b000, 1'b1, "par_bad_3");
        cyc(1'b1, 4'd3, 1'b0, 4'd0, 3'd0, 3'b000, 1'b0, "par_scrub_3");
        idle();
        cyc(1'b1, 4'd3, 1'b0, 4'd0, 3'd0, 3'b000, 1'b0, "par_clean_3");
        idle();
`else
        cyc(1'b1, 4'd3, 1'b0, 4'd0, 3'd0, 3'b000, 1'b0, "noparity_3");
        idle();
        chk("perr_tied", int'(parity_err), 0);
`endif

        idle();
        idle();
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
